// File: rtl/dac_pkg.sv
// Shared definitions for the DAC121S101 serial transmit path.
//   - state_t     : transmitter FSM state encoding (Idle / Shift / Gap)
//   - FRAME_BITS  : length of one serial frame on SDATA
//   - PD_*        : power-down mode field values carried in frame bits [13:12]
package dac_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

endpackage

// File: rtl/dac_transmision_sclk_tick_gen.sv
// Half-period strobe generator for the DAC serial clock.
// Counts clk cycles while enabled and pulses tick on the last cycle of every
// CLK_DIV-cycle half period; clr restarts the count so each frame begins
// with a full-length first half period.
//   clk   : system clock
//   reset : synchronous active-high reset
//   clr   : synchronous counter restart (frame start)
//   en    : count enable (high while shifting)
//   tick  : high on the final cycle of each half period
module sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_transmision.sv
// Serial transmitter for a DAC121S101-class converter (Pmod SPI).
// Packs {2'b00, mode, data_In} into a 16-bit frame and shifts it out MSB
// first. SCLK idles high; SDATA changes with SCLK rising so the converter
// sees CLK_DIV cycles of setup and hold around each falling edge. After the
// frame, CS stays high for GAP_CYCLES cycles before the next start is taken.
//   clk          : system clock
//   reset        : synchronous active-high reset (aborts a frame)
//   tx_start     : start request, sampled only while idle
//   data_In      : 12-bit unsigned sample, latched on acceptance
//   mode         : 2-bit power-down field, latched on acceptance
//   busy         : high from the cycle after acceptance to the end of the gap
//   tx_done_tick : one-cycle pulse as a frame completes
//   CS           : active-low frame select (SYNC)
//   SCLK         : serial clock
//   SDATA        : serial data
module dac_transmision
    import dac_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [11:0] data_In,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        tx_done_tick,
    output logic        CS,
    output logic        SCLK,
    output logic        SDATA
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    state_t                  state, state_nxt;
    logic [FRAME_BITS-1:0]   shreg, shreg_nxt;
    logic [3:0]              bit_cnt, bit_nxt;
    logic [GAP_W-1:0]        gap_cnt, gap_nxt;
    logic                    cs_nxt, sclk_nxt, sdata_nxt, busy_nxt, done_nxt;
    logic                    div_clr, half_tick;
    logic [FRAME_BITS-1:0]   frame;

    assign frame = {2'b00, mode, data_In};

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .en    (state == S_SHIFT),
        .tick  (half_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            CS           <= 1'b1;
            SCLK         <= 1'b1;
            SDATA        <= 1'b0;
            busy         <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            bit_cnt      <= bit_nxt;
            gap_cnt      <= gap_nxt;
            CS           <= cs_nxt;
            SCLK         <= sclk_nxt;
            SDATA        <= sdata_nxt;
            busy         <= busy_nxt;
            tx_done_tick <= done_nxt;
        end
    end

    // Next-state logic computes the next value of every output register, so
    // no input reaches CS/SCLK/SDATA without passing through a flop.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        cs_nxt    = CS;
        sclk_nxt  = SCLK;
        sdata_nxt = SDATA;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        div_clr   = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    state_nxt = S_SHIFT;
                    shreg_nxt = frame;
                    bit_nxt   = '0;
                    cs_nxt    = 1'b0;
                    sclk_nxt  = 1'b1;
                    sdata_nxt = frame[FRAME_BITS-1];
                    busy_nxt  = 1'b1;
                    div_clr   = 1'b1;
                end
            end

            S_SHIFT: begin
                if (half_tick) begin
                    if (SCLK) begin
                        sclk_nxt = 1'b0;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt = S_GAP;
                        shreg_nxt = '0;
                        cs_nxt    = 1'b1;
                        sclk_nxt  = 1'b1;
                        sdata_nxt = 1'b0;
                        gap_nxt   = '0;
                    end else begin
                        // End of a low phase: next bit appears with SCLK rising.
                        shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
                        bit_nxt   = bit_cnt + 1'b1;
                        sclk_nxt  = 1'b1;
                        sdata_nxt = shreg[FRAME_BITS-2];
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                    gap_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_transmision.sv
// Directed bench for dac_transmision: default-parameter instance (u_a) and a
// CLK_DIV=1 / GAP_CYCLES=1 instance (u_b). A serial model samples SDATA on
// SCLK falling edges while CS is low and compares against hand-built frames.
module tb_dac_transmision;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_start_a, tx_start_b;
    logic [11:0] data_a, data_b;
    logic [1:0]  mode_a, mode_b;
    logic        busy_a, tick_a, cs_a, sclk_a, sdata_a;
    logic        busy_b, tick_b, cs_b, sclk_b, sdata_b;

    int errors = 0;
    int checks = 0;
    logic sel = 1'b0;

    always #5 clk = ~clk;

    dac_transmision #(.CLK_DIV(4), .GAP_CYCLES(8)) u_a (
        .clk(clk), .reset(reset), .tx_start(tx_start_a), .data_In(data_a),
        .mode(mode_a), .busy(busy_a), .tx_done_tick(tick_a), .CS(cs_a),
        .SCLK(sclk_a), .SDATA(sdata_a)
    );

    dac_transmision #(.CLK_DIV(1), .GAP_CYCLES(1)) u_b (
        .clk(clk), .reset(reset), .tx_start(tx_start_b), .data_In(data_b),
        .mode(mode_b), .busy(busy_b), .tx_done_tick(tick_b), .CS(cs_b),
        .SCLK(sclk_b), .SDATA(sdata_b)
    );

    wire m_cs    = sel ? cs_b    : cs_a;
    wire m_sclk  = sel ? sclk_b  : sclk_a;
    wire m_sdata = sel ? sdata_b : sdata_a;
    wire m_busy  = sel ? busy_b  : busy_a;
    wire m_tick  = sel ? tick_b  : tick_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a start request on the selected instance; returns just after edge 0.
    task automatic start_frame(input logic s, input logic [11:0] d, input logic [1:0] m, input logic hold);
        @(negedge clk);
        if (s) begin data_b = d; mode_b = m; tx_start_b = 1'b1; end
        else   begin data_a = d; mode_a = m; tx_start_a = 1'b1; end
        @(posedge clk);
        #1;
        if (!hold) begin tx_start_a = 1'b0; tx_start_b = 1'b0; end
    endtask

    // Observe one frame from cycle 1 until the tx_done_tick cycle (bounded).
    task automatic capture(output logic [15:0] cap, output int falls, output int cs_low,
                           output int gap_busy, output int tick_n, output int edge_bad,
                           output int busy_bad);
        logic pcs, psclk, psdata;
        int n;
        cap = '0; falls = 0; cs_low = 0; gap_busy = 0; tick_n = 0;
        edge_bad = 0; busy_bad = 0;
        pcs = 1'b1; psclk = 1'b1; psdata = 1'b0;
        for (n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (!m_cs) cs_low++;
            if (!m_cs && psclk && !m_sclk) begin
                cap = {cap[14:0], m_sdata};
                falls++;
            end
            if (m_sdata != psdata && !(m_sclk && !psclk) && !(!m_cs && pcs) && !(m_cs && !pcs))
                edge_bad++;
            if (m_cs && m_busy) gap_busy++;
            if (m_tick) begin
                if (m_busy) busy_bad++;
                tick_n = n;
                break;
            end
            if (!m_busy) busy_bad++;
            pcs = m_cs; psclk = m_sclk; psdata = m_sdata;
        end
    endtask

    logic [15:0] cap;
    int falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad;
    int bad, tick_seen;

    initial begin
        reset = 1'b1;
        tx_start_a = 1'b0; tx_start_b = 1'b0;
        data_a = '0; data_b = '0; mode_a = '0; mode_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {27'd0, cs_a, sclk_a, sdata_a, busy_a, tick_a}, 32'b11000);
        reset = 1'b0;

        // Idle 50 cycles: outputs must hold their idle values.
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({cs_a, sclk_a, sdata_a, busy_a, tick_a} !== 5'b11000) bad++;
            if ({cs_b, sclk_b, sdata_b, busy_b, tick_b} !== 5'b11000) bad++;
        end
        chk("idle_hold", bad, 0);

        // Frame A5C, mode 00.
        sel = 1'b0;
        start_frame(1'b0, 12'hA5C, 2'b00, 1'b0);
        capture(cap, falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad);
        chk("a5c_data", cap, 16'h0A5C);
        chk("a5c_cs_low", cs_low, 128);
        chk("a5c_tick_cycle", tick_n, 137);
        chk("a5c_gap_busy", gap_busy, 8);
        chk("a5c_sdata_edges", edge_bad, 0);
        chk("a5c_busy", busy_bad, 0);
        @(negedge clk);
        chk("a5c_tick_width", tick_a, 0);

        // Frame FFF, mode 11.
        start_frame(1'b0, 12'hFFF, 2'b11, 1'b0);
        capture(cap, falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad);
        chk("fff_data", cap, 16'h3FFF);
        chk("fff_falls", falls, 16);
        chk("fff_tick_cycle", tick_n, 137);

        // Back-to-back with tx_start held high; data changes mid-frame.
        start_frame(1'b0, 12'h001, 2'b00, 1'b1);
        data_a = 12'h800;
        capture(cap, falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad);
        chk("b2b1_data", cap, 16'h0001);
        chk("b2b1_period", tick_n, 137);
        chk("b2b1_gap_busy", gap_busy, 8);
        capture(cap, falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad);
        tx_start_a = 1'b0;
        chk("b2b2_data", cap, 16'h0800);
        chk("b2b2_cs_low", cs_low, 128);
        chk("b2b2_period", tick_n, 137);
        chk("b2b2_busy", busy_bad, 0);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_no_third", {30'd0, cs_a, busy_a}, 32'b10);

        // Reset during cycle 40 of a frame.
        start_frame(1'b0, 12'hABC, 2'b01, 1'b0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {27'd0, cs_a, sclk_a, sdata_a, busy_a, tick_a}, 32'b11000);
        reset = 1'b0;
        tick_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (tick_a || !cs_a || busy_a) tick_seen++;
        end
        chk("abort_no_tick", tick_seen, 0);
        start_frame(1'b0, 12'h123, 2'b00, 1'b0);
        capture(cap, falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad);
        chk("after_abort_data", cap, 16'h0123);
        chk("after_abort_tick", tick_n, 137);

        // CLK_DIV=1, GAP_CYCLES=1 instance.
        sel = 1'b1;
        start_frame(1'b1, 12'h5A5, 2'b00, 1'b0);
        capture(cap, falls, cs_low, gap_busy, tick_n, edge_bad, busy_bad);
        chk("fast_data", cap, 16'h05A5);
        chk("fast_cs_low", cs_low, 32);
        chk("fast_period", tick_n, 34);
        chk("fast_falls", falls, 16);
        chk("fast_gap_busy", gap_busy, 1);
        chk("fast_sdata_edges", edge_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
